// File: rtl/sap2_alu_if.sv
// ----------------------------------------------------------------------------
// sap2_alu_if
// Bus between the SAP-2 controller/sequencer and the sap2_alu datapath.
//
// Signals:
//   start        controller -> ALU  issue opcode this cycle
//   opcode[3:0]  controller -> ALU  operation select, sampled with start
//   reg_sel      controller -> ALU  operand/destination register index
//   data_in      controller -> ALU  bus data for LDA/LDR
//   busy         ALU -> controller  multi-cycle op in progress
//   done         ALU -> controller  one-cycle pulse, result and flags valid
//   data_out     ALU -> controller  registered output port (written by OUT)
//   acc_zero, acc_negative, acc_carry, acc_overflow   ALU -> controller flags
//
// Modports: master = controller side, slave = ALU side.
// ----------------------------------------------------------------------------
interface sap2_alu_if #(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_REGS   = 4
);
    localparam int REG_SEL_W = $clog2(NUM_REGS);

    logic                  start;
    logic [3:0]            opcode;
    logic [REG_SEL_W-1:0]  reg_sel;
    logic [DATA_WIDTH-1:0] data_in;
    logic                  busy;
    logic                  done;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  acc_zero;
    logic                  acc_negative;
    logic                  acc_carry;
    logic                  acc_overflow;

    modport master (
        output start, opcode, reg_sel, data_in,
        input  busy, done, data_out, acc_zero, acc_negative, acc_carry, acc_overflow
    );

    modport slave (
        input  start, opcode, reg_sel, data_in,
        output busy, done, data_out, acc_zero, acc_negative, acc_carry, acc_overflow
    );
endinterface

// File: rtl/sap2_alu.sv
// ----------------------------------------------------------------------------
// sap2_alu
// Accumulator ALU for the SAP-2 datapath: accumulator, NUM_REGS operand
// registers, Z/N/C/V flags, start/busy/done handshake and an optional
// iterative shift-add multiplier.
//
// Build option:
//   SAP2_ALU_MUL_EN  defined   -> opcode B is an iterative MUL (busy for
//                                 DATA_WIDTH cycles)
//                    undefined -> opcode B is a NOP, busy tied low
//
// Ports:
//   clk      rising-edge clock
//   s_reset  synchronous active-high reset, highest priority
//   bus      sap2_alu_if.slave (start/opcode/reg_sel/data_in in,
//            busy/done/data_out/flags out)
// ----------------------------------------------------------------------------
module sap2_alu #(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_REGS   = 4
) (
    input  logic        clk,
    input  logic        s_reset,
    sap2_alu_if.slave   bus
);
    localparam int W = DATA_WIDTH;

    localparam logic [3:0] OP_CLR = 4'h1;
    localparam logic [3:0] OP_LDA = 4'h2;
    localparam logic [3:0] OP_LDR = 4'h3;
    localparam logic [3:0] OP_ADD = 4'h4;
    localparam logic [3:0] OP_SUB = 4'h5;
    localparam logic [3:0] OP_AND = 4'h6;
    localparam logic [3:0] OP_OR  = 4'h7;
    localparam logic [3:0] OP_XOR = 4'h8;
    localparam logic [3:0] OP_SHL = 4'h9;
    localparam logic [3:0] OP_SHR = 4'hA;
    localparam logic [3:0] OP_OUT = 4'hC;

    // Signed overflow: widen both operands by sign extension, then the result
    // overflowed when the two top bits disagree.
    function automatic logic f_add_ovf(input logic signed [W-1:0] a,
                                       input logic signed [W-1:0] b);
        logic signed [W:0] s;
        s = (W+1)'(a) + (W+1)'(b);
        return s[W] ^ s[W-1];
    endfunction

    function automatic logic f_sub_ovf(input logic signed [W-1:0] a,
                                       input logic signed [W-1:0] b);
        logic signed [W:0] d;
        d = (W+1)'(a) - (W+1)'(b);
        return d[W] ^ d[W-1];
    endfunction

    logic [W-1:0] r_acc;
    logic [W-1:0] r_regs [NUM_REGS];
    logic [W-1:0] r_dout;
    logic         r_done;
    logic         r_z;
    logic         r_n;
    logic         r_c;
    logic         r_v;

    logic [W-1:0] w_b;
    logic [W:0]   w_sum;
    logic [W:0]   w_diff;
    logic [W-1:0] w_res;
    logic         w_wr_acc;
    logic         w_c;
    logic         w_v;
    logic         w_accept;

    // Single-cycle result and flag candidates for the opcode on the bus.
    always_comb begin
        w_b      = r_regs[bus.reg_sel];
        w_sum    = {1'b0, r_acc} + {1'b0, w_b};
        // Top bit of the widened difference is the unsigned borrow (B > acc).
        w_diff   = {1'b0, r_acc} - {1'b0, w_b};
        w_res    = r_acc;
        w_wr_acc = 1'b0;
        w_c      = r_c;
        w_v      = r_v;
        case (bus.opcode)
            OP_CLR: begin w_res = '0;                   w_wr_acc = 1'b1; w_c = 1'b0;       w_v = 1'b0; end
            OP_LDA: begin w_res = bus.data_in;          w_wr_acc = 1'b1; w_c = 1'b0;       w_v = 1'b0; end
            OP_ADD: begin w_res = w_sum[W-1:0];         w_wr_acc = 1'b1; w_c = w_sum[W];   w_v = f_add_ovf(r_acc, w_b); end
            OP_SUB: begin w_res = w_diff[W-1:0];        w_wr_acc = 1'b1; w_c = w_diff[W];  w_v = f_sub_ovf(r_acc, w_b); end
            OP_AND: begin w_res = r_acc & w_b;          w_wr_acc = 1'b1; w_c = 1'b0;       w_v = 1'b0; end
            OP_OR:  begin w_res = r_acc | w_b;          w_wr_acc = 1'b1; w_c = 1'b0;       w_v = 1'b0; end
            OP_XOR: begin w_res = r_acc ^ w_b;          w_wr_acc = 1'b1; w_c = 1'b0;       w_v = 1'b0; end
            OP_SHL: begin w_res = {r_acc[W-2:0], 1'b0}; w_wr_acc = 1'b1; w_c = r_acc[W-1]; w_v = 1'b0; end
            OP_SHR: begin w_res = {1'b0, r_acc[W-1:1]}; w_wr_acc = 1'b1; w_c = r_acc[0];   w_v = 1'b0; end
            default: ;
        endcase
    end

`ifdef SAP2_ALU_MUL_EN
    localparam logic [3:0] OP_MUL = 4'hB;
    localparam int         CNT_W  = $clog2(W + 1);

    logic               r_busy;
    logic [2*W-1:0]     r_mcand;
    logic [2*W-1:0]     r_prod;
    logic [W-1:0]       r_mplier;
    logic [CNT_W-1:0]   r_cnt;
    logic [2*W-1:0]     w_prod_nxt;
    logic               w_mul_last;

    // One multiplier bit per cycle: add the shifted multiplicand when the
    // current LSB of the multiplier is set.
    assign w_prod_nxt = r_prod + (r_mplier[0] ? r_mcand : '0);
    assign w_mul_last = (r_cnt == CNT_W'(W - 1));
    assign bus.busy   = r_busy;
    assign w_accept   = bus.start && !r_busy;
`else
    assign bus.busy   = 1'b0;
    assign w_accept   = bus.start;
`endif

    always_ff @(posedge clk) begin
        if (s_reset) begin
            r_acc  <= '0;
            for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
            r_dout <= '0;
            r_done <= 1'b0;
            r_z    <= 1'b1;
            r_n    <= 1'b0;
            r_c    <= 1'b0;
            r_v    <= 1'b0;
`ifdef SAP2_ALU_MUL_EN
            r_busy   <= 1'b0;
            r_cnt    <= '0;
            r_mcand  <= '0;
            r_prod   <= '0;
            r_mplier <= '0;
`endif
        end else begin
            r_done <= 1'b0;
            if (w_accept) begin
                if (w_wr_acc) begin
                    r_acc <= w_res;
                    r_z   <= (w_res == '0);
                    r_n   <= w_res[W-1];
                    r_c   <= w_c;
                    r_v   <= w_v;
                end
                if (bus.opcode == OP_LDR) r_regs[bus.reg_sel] <= bus.data_in;
                if (bus.opcode == OP_OUT) r_dout <= r_acc;
`ifdef SAP2_ALU_MUL_EN
                if (bus.opcode == OP_MUL) begin
                    r_busy   <= 1'b1;
                    r_cnt    <= '0;
                    r_prod   <= '0;
                    r_mcand  <= {{W{1'b0}}, r_acc};
                    r_mplier <= w_b;
                end else begin
                    r_done <= 1'b1;
                end
`else
                r_done <= 1'b1;
`endif
            end
`ifdef SAP2_ALU_MUL_EN
            // start is never accepted while r_busy, so this branch owns acc
            // and flags for the whole multiply.
            if (r_busy) begin
                r_prod   <= w_prod_nxt;
                r_mcand  <= r_mcand << 1;
                r_mplier <= r_mplier >> 1;
                r_cnt    <= r_cnt + CNT_W'(1);
                if (w_mul_last) begin
                    r_busy <= 1'b0;
                    r_done <= 1'b1;
                    r_acc  <= w_prod_nxt[W-1:0];
                    r_z    <= (w_prod_nxt[W-1:0] == '0);
                    r_n    <= w_prod_nxt[W-1];
                    r_c    <= |w_prod_nxt[2*W-1:W];
                    r_v    <= |w_prod_nxt[2*W-1:W];
                end
            end
`endif
        end
    end

    assign bus.done         = r_done;
    assign bus.data_out     = r_dout;
    assign bus.acc_zero     = r_z;
    assign bus.acc_negative = r_n;
    assign bus.acc_carry    = r_c;
    assign bus.acc_overflow = r_v;
endmodule

// File: doc/sap2_alu.md
Name: sap2_alu

Overview:
- Parametrised successor to the SAP-1 accumulator ALU.
- Adds an operand register file of NUM_REGS entries, XOR and shift ops, and an optional iterative multiplier.
- Adds a start/busy/done handshake and a full flag set (Z, N, C, V).
- Sits between the SAP-2 controller/sequencer and the W bus; the controller issues one opcode per start pulse.

Parameters:
- DATA_WIDTH, 8, width of accumulator, registers, data_in, data_out.
- NUM_REGS, 4, number of operand registers (power of 2, at least 2).
- REG_SEL_W, $clog2(NUM_REGS), width of reg_sel (derived localparam; not overridable).

Ports:
- clk  input  1  rising-edge clock.
- s_reset  input  1  synchronous active-high reset.
- start  input  1  issue opcode this cycle; accepted only when busy=0.
- opcode  input  4  operation select, sampled with start.
- reg_sel  input  REG_SEL_W  operand/destination register index, sampled with start.
- data_in  input  DATA_WIDTH  bus data for LDA/LDR, sampled with start.
- busy  output  1  multi-cycle op in progress.
- done  output  1  one-cycle pulse: result and flags of the accepted op are valid.
- data_out  output  DATA_WIDTH  registered output port, written only by OUT.
- acc_zero  output  1  acc == 0.
- acc_negative  output  1  acc MSB.
- acc_carry  output  1  unsigned carry/borrow/shift-out/mul-high.
- acc_overflow  output  1  signed overflow.

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high, s_reset.
- Reset values: acc=0, all regs=0, data_out=0, busy=0, done=0, acc_zero=1, acc_negative=0, acc_carry=0, acc_overflow=0.
- s_reset has priority over everything. Asserting it mid-MUL aborts the op; no done is issued.
- Opcode encoding (B = reg[reg_sel]; all ops except NOP/LDR/OUT write acc):
  - 0 NOP.
  - 1 CLR: acc=0.
  - 2 LDA: acc=data_in.
  - 3 LDR: reg[reg_sel]=data_in.
  - 4 ADD: acc=acc+B.
  - 5 SUB: acc=acc-B.
  - 6 AND: acc=acc&B.
  - 7 OR: acc=acc|B.
  - 8 XOR: acc=acc^B.
  - 9 SHL: acc=acc<<1, LSB=0.
  - A SHR: logical acc>>1.
  - B MUL.
  - C OUT: data_out=acc.
  - D-F behave as NOP.
- Single-cycle ops: start sampled at edge N. acc, regs, data_out and flags update at edge N. done=1 for the cycle after edge N. busy stays 0, so back-to-back start every cycle is legal.
- Flags, Z/N: recomputed on every acc-writing op (CLR, LDA, ADD..MUL); held otherwise.
- Flags, C:
  - ADD: carry-out.
  - SUB: borrow (B > acc unsigned).
  - SHL: old MSB.
  - SHR: old LSB.
  - MUL: high half of product nonzero.
  - CLR/LDA/AND/OR/XOR clear C.
- Flags, V:
  - ADD/SUB: two's-complement signed overflow.
  - MUL: equals C.
  - All other acc-writing ops clear V.
- Arithmetic is modulo 2^DATA_WIDTH; the result is truncated to DATA_WIDTH bits.
- MUL (multiplier compiled in):
  - At edge N, latch multiplicand=acc and multiplier=B; busy=1 from the cycle after edge N.
  - Shift-add, one multiplier bit per cycle, DATA_WIDTH iterations, 2*DATA_WIDTH internal product.
  - At edge N+DATA_WIDTH: acc=product low half, flags updated, busy=0, done=1 for one cycle.
  - A start in the same cycle done is high is accepted.
  - The register file may be written only by LDR, so B-register changes cannot occur mid-MUL.
- start while busy=1: ignored entirely (no state change, no later replay).
- done never asserts for an ignored start. NOP and D-F still produce done.

Optional Feature:
- Macro: SAP2_ALU_MUL_EN.
- Defined: MUL behaves as described above, including the iterative datapath and busy.
- Undefined:
  - Opcode B is a NOP: acc and flags unchanged, done pulses after one cycle.
  - busy is tied to 0; no multiplier logic is synthesised.

Test Plan:
- Reset: assert s_reset 2 cycles with start=1, opcode=LDA, data_in=0x55 -> acc=0, data_out=0, Z=1, N=C=V=0, busy=done=0.
- Basic ops sequence: LDR r1=0x0F, CLR, ADD r1 -> acc 0x0F; then LDR r2=0xAA, AND r2 -> acc 0x0A; then LDR r3=0x05, OR r3 -> acc 0x0F; then SUB r1 -> acc 0x00, Z=1, C=0; then OUT -> data_out 0x00. done pulses once per op.
- Signed overflow and shifts: LDA 0x7F, LDR r0=0x01, ADD r0 -> acc 0x80, V=1, N=1, C=0; then SHL -> acc 0x00, C=1, Z=1, V=0; then LDA 0x03, SHR -> acc 0x01, C=1.
- Borrow and output: LDA 0x00, LDR r2=0x10, SUB r2 -> acc 0xF0, C=1, N=1, V=0; OUT -> data_out 0xF0; data_out holds through 3 subsequent ADDs.
- MUL (macro defined): LDA 0x0F, LDR r3=0x11, MUL r3 -> busy high exactly 8 cycles, acc 0xFF, C=V=0. Then LDA 0x10, MUL r3 -> acc 0x10, C=V=1. A start=LDA 0x99 during busy -> ignored, acc unaffected.
- Abort and build variant:
  - Start MUL, assert s_reset at busy cycle 4 -> next cycle all reset values, no done.
  - With the macro undefined, MUL -> acc unchanged, busy never 1, done after 1 cycle.
